mul_div_unit: RTL and testbench

- Execute-stage HI/LO unit fed directly by the register file read ports (a, b).
- Performs MULT/MULTU in one cycle, and DIV/DIVU as an iterative 32-step restoring divide.
- Also performs MTHI/MTLO.
- Holds the architectural HI and LO registers; the writeback path reads them for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 158 +++++++++++++++
 tb/tb_mul_div_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// HI/LO execute unit: single-cycle MULT/MULTU, MTHI/MTLO, and a 32-step
// restoring DIV/DIVU whose result is sign-corrected in a final FIX cycle.
module mul_div_unit #(
   parameter int DIV_STEPS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  dbg_state
);

   localparam int CW = $clog2(DIV_STEPS);
   localparam logic [CW-1:0] LAST_STEP = CW'(DIV_STEPS - 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   dvd_q, dvd_d;
   logic [31:0]   dvs_q, dvs_d;
   logic [31:0]   rem_q, rem_d;
   logic          qneg_q, qneg_d;
   logic          rneg_q, rneg_d;
   logic [31:0]   hi_q, hi_d;
   logic [31:0]   lo_q, lo_d;
   logic          done_q, done_d;

   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   abs_a;
   logic [31:0]   abs_b;
   logic [32:0]   trial;
   logic [32:0]   diff;
   logic          is_signed;

   assign prod_s = 64'($signed(a)) * 64'($signed(b));
   assign prod_u = 64'(a) * 64'(b);
   assign abs_a  = a[31] ? -a : a;
   assign abs_b  = b[31] ? -b : b;

   // dvd_q doubles as the quotient: dividend bits shift out the top while
   // quotient bits shift in at the bottom.
   assign trial     = {rem_q, dvd_q[31]};
   assign diff      = trial - {1'b0, dvs_q};
   assign is_signed = (op == OP_DIV);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     {hi_d, lo_d} = prod_s;
                     done_d       = 1'b1;
                  end
                  OP_MULTU: begin
                     {hi_d, lo_d} = prod_u;
                     done_d       = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (b == 32'd0) begin
                        lo_d   = 32'hFFFF_FFFF;
                        hi_d   = a;
                        done_d = 1'b1;
                     end else begin
                        dvd_d   = is_signed ? abs_a : a;
                        dvs_d   = is_signed ? abs_b : b;
                        qneg_d  = is_signed & (a[31] ^ b[31]);
                        rneg_d  = is_signed & a[31];
                        rem_d   = 32'd0;
                        cnt_d   = '0;
                        state_d = RUN;
                     end
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // diff[32] set means the trial subtraction went negative: restore.
            rem_d = diff[32] ? trial[31:0] : diff[31:0];
            dvd_d = {dvd_q[30:0], ~diff[32]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_STEP) state_d = FIX;
         end
         FIX: begin
            lo_d    = qneg_q ? -dvd_q : dvd_q;
            hi_d    = rneg_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= 32'd0;
         dvs_q   <= 32'd0;
         rem_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;

   mul_div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge after the start edge.
   task automatic pulse(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(negedge clk);
      start = 1'b0;
      op    = 3'd6;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic div_run(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input bit disturb);
      logic [31:0] hi0;
      logic [31:0] lo0;
      int          cyc;
      bit          held;
      hi0  = hi;
      lo0  = lo;
      cyc  = 0;
      held = 1'b1;
      pulse(o, x, y);
      while (busy && cyc < 100) begin
         if (hi !== hi0 || lo !== lo0 || done !== 1'b0) held = 1'b0;
         if (disturb) begin
            start = 1'b1;
            op    = 3'd4;
            a     = (cyc % 2 == 0) ? 32'hDEAD_BEEF : $urandom;
            b     = $urandom_range(0, 16);
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      op    = 3'd6;
      chk({tag, " busy_cycles"}, 32'(cyc), 32'd33);
      chk({tag, " hilo_held"}, {31'd0, held}, 32'd1);
      chk({tag, " lo"}, lo, exp_lo);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " done"}, {31'd0, done}, 32'd1);
      @(negedge clk);
      chk({tag, " done_drop"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 3'd6;
      a     = 32'd0;
      b     = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst state", {30'd0, dbg_state}, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // MTHI then MTLO on consecutive edges; neither raises done.
      pulse(3'd4, 32'hAAAA_5555, 32'd0);
      chk("mthi hi", hi, 32'hAAAA_5555);
      chk("mthi done", {31'd0, done}, 32'd0);
      pulse(3'd5, 32'h1234_5678, 32'd0);
      chk("mtlo lo", lo, 32'h1234_5678);
      chk("mtlo hi", hi, 32'hAAAA_5555);
      chk("mtlo done", {31'd0, done}, 32'd0);

      // op 6 leaves everything untouched.
      pulse(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("nop hi", hi, 32'hAAAA_5555);
      chk("nop lo", lo, 32'h1234_5678);
      chk("nop done", {31'd0, done}, 32'd0);

      // Asynchronous reset during RUN aborts the divide.
      pulse(3'd2, 32'hFFFF_FFF9, 32'd2);
      repeat (10) @(negedge clk);
      chk("abort busy_before", {31'd0, busy}, 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("abort hi", hi, 32'd0);
      chk("abort lo", lo, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort state", {30'd0, dbg_state}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      pulse(3'd1, 32'd3, 32'd5);
      chk("multu3x5 lo", lo, 32'd15);
      chk("multu3x5 hi", hi, 32'd0);
      chk("multu3x5 done", {31'd0, done}, 32'd1);
      @(negedge clk);
      chk("multu3x5 done_drop", {31'd0, done}, 32'd0);

      // Signed vs unsigned multiply of the same bit patterns.
      pulse(3'd0, 32'hFFFF_FFFE, 32'd3);
      chk("mult hi", hi, 32'hFFFF_FFFF);
      chk("mult lo", lo, 32'hFFFF_FFFA);
      chk("mult done", {31'd0, done}, 32'd1);
      chk("mult busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("mult done_drop", {31'd0, done}, 32'd0);
      pulse(3'd1, 32'hFFFF_FFFE, 32'd3);
      chk("multu hi", hi, 32'h0000_0002);
      chk("multu lo", lo, 32'hFFFF_FFFA);
      @(negedge clk);

      div_run("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
      div_run("divu 100/7", 3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      div_run("div 7/-2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
      div_run("div ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      div_run("divu big", 3'd3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

      // Divide by zero completes in one edge without entering RUN.
      pulse(3'd3, 32'h0000_1234, 32'd0);
      chk("divz lo", lo, 32'hFFFF_FFFF);
      chk("divz hi", hi, 32'h0000_1234);
      chk("divz done", {31'd0, done}, 32'd1);
      chk("divz busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      chk("divz busy_after", {31'd0, busy}, 32'd0);
      chk("divz done_drop", {31'd0, done}, 32'd0);

      // Starts and operand changes while busy must not disturb the divide.
      div_run("divu busy_ignore", 3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
